rf_access_ctrl: RTL
===================

Name: rf_access_ctrl

Overview:
- Sequencing and arbitration controller placed in front of the 32x32 dual-read register file.
- Accepts register-file transactions from two requesters (req0 = core datapath, req1 = debug/loader port) and grants them round-robin.
- Drives the file's exclusive READ/WRITE strobes and addresses one phase per cycle.
- Returns captured read data on a shared response bus tagged with the requester id.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 5, width of register addresses.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  (N=0,1) request present; must hold stable until reqN_ready.
- reqN_op  in  2  01=read, 10=write, 11=exchange (read then write), 00=illegal.
- reqN_addr_r1, reqN_addr_r2  in  ADDR_WIDTH  read addresses.
- reqN_addr_w  in  ADDR_WIDTH  write address.
- reqN_data_w  in  DATA_WIDTH  write data.
- reqN_ready  out  1  accept pulse; combinational.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  requester id of the completing transaction.
- rsp_err  out  1  high with rsp_valid for an illegal op.
- rsp_data1, rsp_data2  out  DATA_WIDTH  captured read data.
- rf_read, rf_write  out  1  register-file strobes; never high together.
- rf_addr_r1, rf_addr_r2, rf_addr_w  out  ADDR_WIDTH  register-file addresses.
- rf_data_w  out  DATA_WIDTH  register-file write data.
- rf_data_r1, rf_data_r2  in  DATA_WIDTH  register-file read data.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; last_grant=1, so req0 wins first.
  - All outputs 0, including rsp_data1/2 and rf_* addresses and data.
  - An in-flight transaction is discarded with no response.
- States: IDLE, RD, WR, DONE, one-hot encoded.
- IDLE arbitration:
  - Only one valid: that requester wins.
  - Both valid: the one not equal to last_grant wins.
  - The winner gets reqN_ready=1 in this cycle.
  - On the same edge: latch op, addresses, data and id; update last_grant.
  - Next state: 01 or 11 -> RD; 10 -> WR; 00 -> DONE with err flag set.
  - No valid: stay in IDLE; ready outputs stay 0.
- RD:
  - rf_read=1, rf_write=0; rf_addr_r1/r2 = latched addresses.
  - rf_data_r1/r2 captured into rsp_data1/2 at the end of the cycle.
  - Next state: op 11 -> WR, else DONE.
- WR:
  - rf_write=1, rf_read=0; rf_addr_w and rf_data_w = latched values.
  - The file writes on this cycle's rising edge at exit.
  - Next state: DONE.
- DONE:
  - rsp_valid=1; rsp_id = latched id; rsp_err = err flag.
  - rsp_data1/2 hold the last captured values. They are unchanged by write-only ops, and rsp_data is don't-care when rsp_err=1.
  - Next state: IDLE.
- Latency (accept cycle = 0):
  - read: rsp_valid at cycle 2.
  - write: rsp_valid at cycle 2.
  - exchange: rsp_valid at cycle 3.
  - illegal: rsp_valid at cycle 1.
- Throughput: one transaction in flight. A new request is accepted only in IDLE, never in DONE.
- Strobe rules:
  - rf_read and rf_write are 0 in IDLE and DONE.
  - rf_* addresses and write data hold their latched values until the next accept.
- Exchange returns the pre-write contents: the read phase precedes the write phase. If addr_r1 == addr_w, rsp_data1 = old value.
- reqN_valid dropping before ready is a protocol violation; no recovery is required.
- Fairness: alternating grants while both requesters stay valid; no starvation.

Optional Feature:
- RF_R0_ZERO_EN defined:
  - Register 0 is hardwired to zero.
  - A WR phase with latched addr_w==0 keeps rf_write=0; the transaction still completes normally with rsp_err=0.
  - In RD, a read address of 0 captures 0 instead of rf_data_rN.
- RF_R0_ZERO_EN undefined: register 0 is an ordinary register.

Test Plan:
1. Reset mid-exchange (RST low during WR) -> all outputs 0 immediately, rf_write=0, no rsp_valid; afterwards req0 wins a simultaneous request.
2. req0 write r5=0xDEADBEEF, then read r1=5 r2=5 -> rsp_valid at cycle 2 each, rsp_id=0, rsp_data1=rsp_data2=0xDEADBEEF.
3. req0 and req1 both held valid with reads -> grants alternate 0,1,0,1; each response id matches its grant.
4. Exchange on r7 (holds 0x11) with data 0x22 -> rsp_data1=0x11 at cycle 3; a following read of r7 returns 0x22.
5. op=00 from req1 -> rsp_valid at cycle 1, rsp_err=1, rsp_id=1, rf_read=rf_write=0 throughout.
6. With RF_R0_ZERO_EN: write r0=0x55 then read r0 -> rf_write never asserted, rsp_data1=0. Without the macro, the same sequence reads back 0x55.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// rf_access_ctrl
//
// Purpose:
//   Sequencing and arbitration controller in front of a 32x32 dual-read
//   register file. Two requesters (req0 = core datapath, req1 = debug/loader)
//   are granted round-robin. One transaction is in flight at a time. Each
//   transaction is split into an exclusive READ phase and/or WRITE phase. A
//   single-cycle response then carries the captured read data and the id of
//   the requester.
//
// Ports:
//   CLK, RST                    clock (rising edge); asynchronous active-low reset
//   reqN_valid/op/addr_*/data_w request channel N (N = 0, 1)
//                               op: 01 read, 10 write, 11 exchange, 00 illegal
//   reqN_ready                  combinational accept pulse (IDLE only)
//   rsp_valid/id/err/data1/2    completion pulse, requester id, illegal-op flag,
//                               captured read data
//   rf_read, rf_write           register-file strobes (never both high)
//   rf_addr_r1/r2/w, rf_data_w  register-file addresses and write data
//   rf_data_r1/r2               register-file read data
//
// Build option:
//   RF_R0_ZERO_EN  register 0 is hardwired to zero. Writes to r0 suppress
//                  rf_write, and reads of r0 capture zero.
// -----------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    input  logic [1:0]            req0_op,
    input  logic [ADDR_WIDTH-1:0] req0_addr_r1,
    input  logic [ADDR_WIDTH-1:0] req0_addr_r2,
    input  logic [ADDR_WIDTH-1:0] req0_addr_w,
    input  logic [DATA_WIDTH-1:0] req0_data_w,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [1:0]            req1_op,
    input  logic [ADDR_WIDTH-1:0] req1_addr_r1,
    input  logic [ADDR_WIDTH-1:0] req1_addr_r2,
    input  logic [ADDR_WIDTH-1:0] req1_addr_w,
    input  logic [DATA_WIDTH-1:0] req1_data_w,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_data1,
    output logic [DATA_WIDTH-1:0] rsp_data2,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RD   = 4'b0010,
        ST_WR   = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    localparam logic [1:0] OP_ILLEGAL  = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_WRITE    = 2'b10;
    localparam logic [1:0] OP_EXCHANGE = 2'b11;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_WIDTH-1:0] rsp_data2_q, rsp_data2_d;

    logic                  grant0_s, grant1_s;
    logic [1:0]            sel_op_s;
    logic [ADDR_WIDTH-1:0] sel_addr_r1_s, sel_addr_r2_s, sel_addr_w_s;
    logic [DATA_WIDTH-1:0] sel_data_w_s;

    // Value captured from the read port. With r0 hardwired, an r0 read
    // yields zero no matter what the file drives.
    function automatic logic [DATA_WIDTH-1:0] rd_capture(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data
    );
`ifdef RF_R0_ZERO_EN
        if (addr == {ADDR_WIDTH{1'b0}}) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return data;
        end
`else
        if (addr == {ADDR_WIDTH{1'b0}}) begin
            return data;
        end else begin
            return data;
        end
`endif
    endfunction

    // Round-robin arbitration. On a tie, the requester that did not win last time wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Select the fields of the winning requester.
    always_comb begin
        sel_op_s      = req0_op;
        sel_addr_r1_s = req0_addr_r1;
        sel_addr_r2_s = req0_addr_r2;
        sel_addr_w_s  = req0_addr_w;
        sel_data_w_s  = req0_data_w;
        if (grant1_s) begin
            sel_op_s      = req1_op;
            sel_addr_r1_s = req1_addr_r1;
            sel_addr_r2_s = req1_addr_r2;
            sel_addr_w_s  = req1_addr_w;
            sel_data_w_s  = req1_data_w;
        end else begin
            sel_op_s      = req0_op;
        end
    end

    // Next-state logic, transaction latching and read-data capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        err_d        = err_q;
        op_d         = op_q;
        addr_r1_d    = addr_r1_q;
        addr_r2_d    = addr_r2_q;
        addr_w_d     = addr_w_q;
        data_w_d     = data_w_q;
        rsp_data1_d  = rsp_data1_q;
        rsp_data2_d  = rsp_data2_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    id_d         = grant1_s;
                    last_grant_d = grant1_s;
                    op_d         = sel_op_s;
                    addr_r1_d    = sel_addr_r1_s;
                    addr_r2_d    = sel_addr_r2_s;
                    addr_w_d     = sel_addr_w_s;
                    data_w_d     = sel_data_w_s;
                    err_d        = (sel_op_s == OP_ILLEGAL);
                    case (sel_op_s)
                        OP_READ:     state_d = ST_RD;
                        OP_EXCHANGE: state_d = ST_RD;
                        OP_WRITE:    state_d = ST_WR;
                        default:     state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                rsp_data1_d = rd_capture(addr_r1_q, rf_data_r1);
                rsp_data2_d = rd_capture(addr_r2_q, rf_data_r2);
                if (op_q == OP_EXCHANGE) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and transaction registers. Reset drops any in-flight transaction.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            op_q         <= 2'b00;
            addr_r1_q    <= {ADDR_WIDTH{1'b0}};
            addr_r2_q    <= {ADDR_WIDTH{1'b0}};
            addr_w_q     <= {ADDR_WIDTH{1'b0}};
            data_w_q     <= {DATA_WIDTH{1'b0}};
            rsp_data1_q  <= {DATA_WIDTH{1'b0}};
            rsp_data2_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            err_q        <= err_d;
            op_q         <= op_d;
            addr_r1_q    <= addr_r1_d;
            addr_r2_q    <= addr_r2_d;
            addr_w_q     <= addr_w_d;
            data_w_q     <= data_w_d;
            rsp_data1_q  <= rsp_data1_d;
            rsp_data2_q  <= rsp_data2_d;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // The strobes decode directly from the one-hot state register, so they are
    // mutually exclusive by construction.
    assign rf_read   = (state_q == ST_RD);
`ifdef RF_R0_ZERO_EN
    assign rf_write  = (state_q == ST_WR) && (addr_w_q != {ADDR_WIDTH{1'b0}});
`else
    assign rf_write  = (state_q == ST_WR);
`endif
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_id     = id_q;
    assign rsp_err    = (state_q == ST_DONE) && err_q;
    assign rsp_data1  = rsp_data1_q;
    assign rsp_data2  = rsp_data2_q;
    assign rf_addr_r1 = addr_r1_q;
    assign rf_addr_r2 = addr_r2_q;
    assign rf_addr_w  = addr_w_q;
    assign rf_data_w  = data_w_q;

endmodule
